// File: rtl/a2b_pa_packetizer.sv
// Alice-side PA transmit packetizer: frames secret-key-length packets and
// PA random-bit packets as 32-bit header+payload streams into the A_TX_pa FIFO.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reset_pa_parameter        clears random-bit address and packet count (IDLE only)
//   skl_start / skl_value     request + value for a secret-key-length packet
//   rb_start                  request for the next random-bit packet
//   busy, pkt_done            packet in flight / one-cycle completion pulse
//   rb_all_sent               all random-bit packets of the round have been sent
//   A_TX_pa_*                 FIFO write side (wr_en combinational from state and full)
//   A_PArandombit_*           64-bit random-bit BRAM read port
module a2b_pa_packetizer #(
  parameter logic [3:0]  SKL_TYPE   = 4'h2,
  parameter logic [3:0]  RB_TYPE    = 4'h3,
  parameter logic [3:0]  LEN_257    = 4'h1,
  parameter logic [3:0]  LEN_1028   = 4'h4,
  parameter int unsigned BRAM_LAT   = 2,
  parameter int unsigned RB_ENTRIES = 512,
  parameter int unsigned RB_PKTS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_pa_parameter,
  input  logic        skl_start,
  input  logic [31:0] skl_value,
  input  logic        rb_start,
  output logic        busy,
  output logic        pkt_done,
  output logic        rb_all_sent,
  output logic        A_TX_pa_wr_clk,
  output logic        A_TX_pa_wr_en,
  output logic [31:0] A_TX_pa_wr_din,
  input  logic        A_TX_pa_full,
  output logic        A_PArandombit_clk,
  output logic        A_PArandombit_en,
  output logic [13:0] A_PArandombit_addr,
  input  logic [63:0] A_PArandombit_dout
);

  localparam int unsigned DW  = 32;
  localparam int unsigned HW  = 64;
  localparam int unsigned AW  = 14;
  localparam int unsigned ECW = $clog2(RB_ENTRIES + 1);
  localparam int unsigned PCW = $clog2(RB_PKTS + 1);
  localparam int unsigned WCW = 2;

  localparam logic [DW-1:0] SKL_HDR = {SKL_TYPE, LEN_257, 9'd1, 15'd0};
  localparam logic [DW-1:0] RB_HDR  = {RB_TYPE, LEN_1028, 24'd0};

  typedef enum logic [2:0] {
    IDLE, HDR, SKL_WORD, RB_RD, RB_WAIT, RB_HI, RB_LO, DONE
  } state_t;

  state_t          state, state_nxt;
  logic            is_rb;
  logic [DW-1:0]   skl_q;
  logic [HW-1:0]   hold;
  logic [ECW-1:0]  ent_cnt;
  logic [PCW-1:0]  pkt_cnt;
  logic [WCW-1:0]  wait_cnt;
  logic            ent_last;
  logic            capture;
  logic            accept_skl;
  logic            accept_rb;

  assign A_TX_pa_wr_clk    = clk;
  assign A_PArandombit_clk = clk;
  assign A_PArandombit_en  = 1'b1;

  assign rb_all_sent = (pkt_cnt == PCW'(RB_PKTS));
  assign ent_last    = (ent_cnt == ECW'(RB_ENTRIES - 1));

  // Write strobe: only in a write state and only when the FIFO can take it.
  assign A_TX_pa_wr_en = (state inside {HDR, SKL_WORD, RB_HI, RB_LO}) && !A_TX_pa_full;

  // SKL wins over RB; RB is refused once the round is complete.
  assign accept_skl = (state == IDLE) && skl_start;
  assign accept_rb  = (state == IDLE) && !skl_start && rb_start && !rb_all_sent;

  // Next-state logic; write states advance only on an accepted write.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:     if (accept_skl || accept_rb) state_nxt = HDR;
      HDR:      if (A_TX_pa_wr_en) state_nxt = is_rb ? RB_RD : SKL_WORD;
      SKL_WORD: if (A_TX_pa_wr_en) state_nxt = DONE;
      RB_RD: begin
        if (BRAM_LAT == 1) begin
          state_nxt = RB_HI;
          capture   = 1'b1;
        end else begin
          state_nxt = RB_WAIT;
        end
      end
      RB_WAIT: begin
        if (wait_cnt == WCW'(BRAM_LAT - 2)) begin
          state_nxt = RB_HI;
          capture   = 1'b1;
        end
      end
      RB_HI:    if (A_TX_pa_wr_en) state_nxt = RB_LO;
      RB_LO:    if (A_TX_pa_wr_en) state_nxt = ent_last ? DONE : RB_RD;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register and datapath; wr_din is preloaded with the word the next state writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      pkt_done           <= 1'b0;
      A_TX_pa_wr_din     <= '0;
      A_PArandombit_addr <= '0;
      is_rb              <= 1'b0;
      skl_q              <= '0;
      hold               <= '0;
      ent_cnt            <= '0;
      pkt_cnt            <= '0;
      wait_cnt           <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      pkt_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept_skl) begin
            is_rb          <= 1'b0;
            skl_q          <= skl_value;
            A_TX_pa_wr_din <= SKL_HDR;
          end else if (accept_rb) begin
            is_rb          <= 1'b1;
            A_TX_pa_wr_din <= RB_HDR;
          end
          if (reset_pa_parameter) begin
            A_PArandombit_addr <= '0;
            pkt_cnt            <= '0;
          end
        end
        HDR:     if (A_TX_pa_wr_en && !is_rb) A_TX_pa_wr_din <= skl_q;
        RB_RD:   wait_cnt <= '0;
        RB_WAIT: wait_cnt <= wait_cnt + WCW'(1);
        RB_HI:   if (A_TX_pa_wr_en) A_TX_pa_wr_din <= hold[DW-1:0];
        RB_LO: begin
          if (A_TX_pa_wr_en) begin
            A_PArandombit_addr <= A_PArandombit_addr + AW'(1);
            ent_cnt            <= ent_last ? '0 : ent_cnt + ECW'(1);
          end
        end
        DONE:    if (is_rb) pkt_cnt <= pkt_cnt + PCW'(1);
        default: ;
      endcase
      // BRAM data lands exactly BRAM_LAT cycles after entering RB_RD.
      if (capture) begin
        hold           <= A_PArandombit_dout;
        A_TX_pa_wr_din <= A_PArandombit_dout[HW-1:DW];
      end
    end
  end

endmodule

// File: tb/tb_a2b_pa_packetizer.sv
// Bench for a2b_pa_packetizer: a table of request vectors, hand-written timing,
// round-limit and mid-packet reset sequences, and a randomized phase, all
// checked against a packet-level reference model of the FIFO stream.
module tb_a2b_pa_packetizer;

  localparam logic [31:0] SKL_HDR = 32'h2100_8000;
  localparam logic [31:0] RB_HDR  = 32'h3400_0000;
  localparam int NE = 512;
  localparam int NP = 32;

  logic        clk;
  logic        rst;
  logic        reset_pa_parameter;
  logic        skl_start;
  logic [31:0] skl_value;
  logic        rb_start;
  logic        busy;
  logic        pkt_done;
  logic        rb_all_sent;
  logic        A_TX_pa_wr_clk;
  logic        A_TX_pa_wr_en;
  logic [31:0] A_TX_pa_wr_din;
  logic        A_TX_pa_full;
  logic        A_PArandombit_clk;
  logic        A_PArandombit_en;
  logic [13:0] A_PArandombit_addr;
  logic [63:0] A_PArandombit_dout;

  a2b_pa_packetizer dut (
    .clk                (clk),
    .rst                (rst),
    .reset_pa_parameter (reset_pa_parameter),
    .skl_start          (skl_start),
    .skl_value          (skl_value),
    .rb_start           (rb_start),
    .busy               (busy),
    .pkt_done           (pkt_done),
    .rb_all_sent        (rb_all_sent),
    .A_TX_pa_wr_clk     (A_TX_pa_wr_clk),
    .A_TX_pa_wr_en      (A_TX_pa_wr_en),
    .A_TX_pa_wr_din     (A_TX_pa_wr_din),
    .A_TX_pa_full       (A_TX_pa_full),
    .A_PArandombit_clk  (A_PArandombit_clk),
    .A_PArandombit_en   (A_PArandombit_en),
    .A_PArandombit_addr (A_PArandombit_addr),
    .A_PArandombit_dout (A_PArandombit_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Random-bit BRAM content: entry i = {A000_0000+i, B000_0000+i}.
  function automatic logic [63:0] entry(input int a);
    logic [31:0] i;
    i = 32'(a & 16383);
    return {32'hA000_0000 + i, 32'hB000_0000 + i};
  endfunction

  // BRAM model: address registered once, data valid BRAM_LAT(=2) edges after the address.
  logic [13:0] a_d;
  always @(posedge clk) a_d <= A_PArandombit_addr;
  assign A_PArandombit_dout = entry(int'(a_d));

  // FIFO-side monitor, sampled on the falling edge.
  logic [31:0] got_q[$];
  int done_cnt = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (A_TX_pa_wr_en) got_q.push_back(A_TX_pa_wr_din);
    if (A_TX_pa_wr_en && A_TX_pa_full) viol++;
    if (pkt_done) done_cnt++;
  end

  // Reference model: packet stream produced by a request, plus round bookkeeping.
  logic [31:0] exp_q[$];
  int m_addr = 0;
  int m_pkts = 0;

  task automatic build_exp(input bit skl, input bit rb, input logic [31:0] val);
    logic [63:0] e;
    exp_q.delete();
    if (skl) begin
      exp_q.push_back(SKL_HDR);
      exp_q.push_back(val);
    end else if (rb && m_pkts < NP) begin
      exp_q.push_back(RB_HDR);
      for (int i = 0; i < NE; i++) begin
        e = entry(m_addr + i);
        exp_q.push_back(e[63:32]);
        exp_q.push_back(e[31:0]);
      end
      m_addr = (m_addr + NE) % 16384;
      m_pkts++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare got_q[base..] with exp_q; prefix_only ignores extra got words.
  task automatic cmp_words(input string nm, input int base, input bit prefix_only);
    int n;
    int bad;
    n = got_q.size() - base;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && got_q[base + i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0 || (prefix_only ? n < exp_q.size() : n != exp_q.size())) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: word %0d got %h expected %h", nm, bad, got_q[base + bad], exp_q[bad]);
      else
        $display("FAIL %s: word count got %0d expected %0d", nm, n, exp_q.size());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int last_base;

  // Issue one request, run it to completion (optionally with backpressure and
  // ignored mid-packet pokes), and check stream, pkt_done and address.
  task automatic run_req(input string nm, input bit skl, input bit rb, input logic [31:0] val,
                         input bit stall, input bit poke);
    int base;
    int dbase;
    int n;
    bit exp_busy;
    build_exp(skl, rb, val);
    exp_busy = (exp_q.size() != 0);
    base = got_q.size();
    last_base = base;
    dbase = done_cnt;
    skl_start = skl;
    rb_start  = rb;
    skl_value = val;
    cyc();
    skl_start = 1'b0;
    rb_start  = 1'b0;
    skl_value = $urandom;
    chk({nm, "_busy"}, 64'(busy), 64'(exp_busy));
    n = 0;
    while (busy && n < 20000) begin
      A_TX_pa_full = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      skl_start          = poke && n == 40;
      rb_start           = poke && n == 40;
      reset_pa_parameter = poke && n == 40;
      cyc();
      n++;
    end
    A_TX_pa_full = 1'b0;
    skl_start = 1'b0;
    rb_start = 1'b0;
    reset_pa_parameter = 1'b0;
    repeat (3) cyc();
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    cmp_words({nm, "_words"}, base, 1'b0);
    chk({nm, "_done"}, 64'(done_cnt - dbase), 64'(exp_busy ? 1 : 0));
    chk({nm, "_addr"}, 64'(A_PArandombit_addr), 64'(m_addr));
  endtask

  typedef struct {
    bit          skl;
    bit          rb;
    logic [31:0] val;
    bit          stall;
    bit          poke;
    int          exp_n;
    logic [31:0] exp_hdr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base;
    int n;
    int iter;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_1F40, 1'b0, 1'b0, 2,    SKL_HDR};
    tbl[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2,    SKL_HDR};
    tbl[2] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1025, RB_HDR};
    tbl[3] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1025, RB_HDR};
    tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2,    SKL_HDR};
    tbl[5] = '{1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 0,    32'h0};

    rst = 1'b1;
    reset_pa_parameter = 1'b0;
    skl_start = 1'b0;
    skl_value = 32'h0;
    rb_start = 1'b0;
    A_TX_pa_full = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_wr_en", 64'(A_TX_pa_wr_en), 64'd0);
    chk("rst_wr_din", 64'(A_TX_pa_wr_din), 64'd0);
    chk("rst_addr", 64'(A_PArandombit_addr), 64'd0);
    chk("rst_all_sent", 64'(rb_all_sent), 64'd0);
    chk("bram_en", 64'(A_PArandombit_en), 64'd1);
    chk("wr_clk", 64'(A_TX_pa_wr_clk), 64'(clk));
    rst = 1'b0;
    cyc();

    // SKL cycle timing: start cycle 0, header 1, payload 2, pkt_done 3
    skl_start = 1'b1;
    skl_value = 32'h0000_1F40;
    cyc();
    skl_start = 1'b0;
    skl_value = 32'h0;
    chk("skl_c1_busy", 64'(busy), 64'd1);
    chk("skl_c1_wr_en", 64'(A_TX_pa_wr_en), 64'd1);
    chk("skl_c1_din", 64'(A_TX_pa_wr_din), 64'(SKL_HDR));
    cyc();
    chk("skl_c2_wr_en", 64'(A_TX_pa_wr_en), 64'd1);
    chk("skl_c2_din", 64'(A_TX_pa_wr_din), 64'h0000_1F40);
    cyc();
    chk("skl_c3_done", 64'(pkt_done), 64'd1);
    chk("skl_c3_wr_en", 64'(A_TX_pa_wr_en), 64'd0);
    chk("skl_c3_busy", 64'(busy), 64'd1);
    cyc();
    chk("skl_c4_busy", 64'(busy), 64'd0);
    chk("skl_c4_done", 64'(pkt_done), 64'd0);
    cyc();

    // Vector table
    for (int v = 0; v < 6; v++) begin
      run_req($sformatf("vec%0d", v), tbl[v].skl, tbl[v].rb, tbl[v].val, tbl[v].stall, tbl[v].poke);
      chk($sformatf("vec%0d_n", v), 64'(got_q.size() - last_base), 64'(tbl[v].exp_n));
      if (got_q.size() > last_base)
        chk($sformatf("vec%0d_hdr", v), 64'(got_q[last_base]), 64'(tbl[v].exp_hdr));
    end

    // Randomized requests until the round is complete
    iter = 0;
    while (m_pkts < NP && iter < 200) begin
      if ($urandom_range(0, 3) == 0)
        run_req($sformatf("rnd%0d_skl", iter), 1'b1, 1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 3) == 0), 1'b0);
      else
        run_req($sformatf("rnd%0d_rb", iter), 1'b0, 1'b1, $urandom,
                ($urandom_range(0, 7) == 0), 1'b0);
      iter++;
    end

    // Round limit
    chk("round_all_sent", 64'(rb_all_sent), 64'd1);
    run_req("rb33", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    reset_pa_parameter = 1'b1;
    cyc();
    reset_pa_parameter = 1'b0;
    m_addr = 0;
    m_pkts = 0;
    chk("rpp_all_sent", 64'(rb_all_sent), 64'd0);
    chk("rpp_addr", 64'(A_PArandombit_addr), 64'd0);

    // Reset at payload word 300 of an RB packet
    build_exp(1'b0, 1'b1, 32'h0);
    base = got_q.size();
    rb_start = 1'b1;
    cyc();
    rb_start = 1'b0;
    n = 0;
    while (got_q.size() - base < 301 && n < 5000) begin
      cyc();
      n++;
    end
    chk("mid_reached", 64'(got_q.size() - base >= 301), 64'd1);
    rst = 1'b1;
    cyc();
    chk("mid_wr_en", 64'(A_TX_pa_wr_en), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_addr", 64'(A_PArandombit_addr), 64'd0);
    rst = 1'b0;
    exp_q = exp_q[0:300];
    cmp_words("mid_prefix", base, 1'b1);
    m_addr = 0;
    m_pkts = 0;
    cyc();
    run_req("after_rst", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    chk("no_write_while_full", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
